// File: rtl/vehicle_sensor_conditioner_if.sv
// Sensor-side bundle between the loop detectors / controller and the conditioner.
// master = stimulus/controller side, slave = conditioner.
interface vehicle_sensor_conditioner_if;
  logic [3:0]  raw_1th;
  logic [3:0]  raw_5th;
  logic [3:0]  clear;
  logic [3:0]  sensor_1th;
  logic [3:0]  sensor_5th;
  logic [31:0] arrivals;
  logic [3:0]  fault;

  modport master (
    output raw_1th, raw_5th, clear,
    input  sensor_1th, sensor_5th, arrivals, fault
  );

  modport slave (
    input  raw_1th, raw_5th, clear,
    output sensor_1th, sensor_5th, arrivals, fault
  );
endinterface

// File: rtl/vehicle_sensor_conditioner.sv
// Loop-detector conditioner: 2-flop sync, debounce, position-5 occupancy hold, arrival counts.
// Optional stuck-detector fault masking is built when STUCK_DETECT_EN is defined.
module vehicle_sensor_conditioner #(
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned OCC_MIN      = 8,
  parameter int unsigned STUCK_CYCLES = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  vehicle_sensor_conditioner_if.slave  bus
);

  localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE - 1);
  localparam logic [7:0]  OCC_LIM = 8'(OCC_MIN);
  localparam logic [15:0] STK_LIM = 16'(STUCK_CYCLES);

  // Channels 0..3 are position-1 detectors, 4..7 are position-5 detectors.
  logic [7:0]      raw;
  logic [7:0]      s1_q, s2_q;
  logic [7:0]      deb_q, deb_d;
  logic [7:0][7:0] db_cnt_q, db_cnt_d;
  logic [3:0][7:0] occ_q, occ_d;
  logic [3:0][7:0] arr_q, arr_d;
  logic [3:0]      deb1_prev_q, rise;
  logic [3:0]      sensor_1th_q, sensor_1th_d;
  logic [3:0]      sensor_5th_q, sensor_5th_d;
  logic [3:0]      fault_q, inhibit;

  assign raw = {bus.raw_5th, bus.raw_1th};

  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 8; i++) begin
      if (s2_q[i] == deb_q[i]) begin
        db_cnt_d[i] = 8'd0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        deb_d[i]    = s2_q[i];
        db_cnt_d[i] = 8'd0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 8'd1;
      end
    end
  end

  assign rise = deb_q[3:0] & ~deb1_prev_q;

  always_comb begin
    occ_d        = occ_q;
    arr_d        = arr_q;
    sensor_1th_d = '0;
    sensor_5th_d = '0;
    for (int i = 0; i < 4; i++) begin
      sensor_1th_d[i] = deb_q[i] & ~inhibit[i];
      if (deb_q[4+i]) begin
        occ_d[i]        = (occ_q[i] >= OCC_LIM) ? occ_q[i] : occ_q[i] + 8'd1;
        sensor_5th_d[i] = (occ_q[i] >= OCC_LIM) & ~inhibit[i];
      end else begin
        occ_d[i]        = 8'd0;
        sensor_5th_d[i] = 1'b0;
      end
      // A clear on the same edge as a new arrival keeps that arrival.
      if (bus.clear[i]) begin
        arr_d[i] = {7'd0, rise[i]};
      end else if (rise[i] && arr_q[i] != 8'hFF) begin
        arr_d[i] = arr_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= '0;
      s2_q         <= '0;
      deb_q        <= '0;
      db_cnt_q     <= '0;
      occ_q        <= '0;
      arr_q        <= '0;
      deb1_prev_q  <= '0;
      sensor_1th_q <= '0;
      sensor_5th_q <= '0;
    end else begin
      s1_q         <= raw;
      s2_q         <= s1_q;
      deb_q        <= deb_d;
      db_cnt_q     <= db_cnt_d;
      occ_q        <= occ_d;
      arr_q        <= arr_d;
      deb1_prev_q  <= deb_q[3:0];
      sensor_1th_q <= sensor_1th_d;
      sensor_5th_q <= sensor_5th_d;
    end
  end

`ifdef STUCK_DETECT_EN
  logic [3:0][15:0] stk_q, stk_d;
  logic [3:0]       fault_d;

  always_comb begin
    stk_d   = stk_q;
    fault_d = fault_q;
    for (int i = 0; i < 4; i++) begin
      if (!deb_d[i]) begin
        stk_d[i]   = 16'd0;
        fault_d[i] = 1'b0;
      end else if (deb_q[i]) begin
        if (stk_q[i] != STK_LIM) stk_d[i] = stk_q[i] + 16'd1;
        if (stk_d[i] == STK_LIM) fault_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stk_q   <= '0;
      fault_q <= '0;
    end else begin
      stk_q   <= stk_d;
      fault_q <= fault_d;
    end
  end

  // Mask on both the setting and the clearing edge so the sensor never glitches high.
  assign inhibit = fault_q | fault_d;
`else
  logic unused_stk;
  assign unused_stk = ^STK_LIM;
  assign fault_q    = '0;
  assign inhibit    = '0;
`endif

  assign bus.sensor_1th = sensor_1th_q;
  assign bus.sensor_5th = sensor_5th_q;
  assign bus.arrivals   = arr_q;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Directed scoreboard bench: expectations are queued per edge, a negedge monitor checks them.
module tb_vehicle_sensor_conditioner;
  localparam int F_S1 = 0, F_S5 = 1, F_ARR = 2, F_FLT = 3;

  typedef struct {
    int          cyc;
    int          fld;
    logic [31:0] mask;
    logic [31:0] val;
    string       nm;
  } exp_t;

  logic clk, rst;
  int   edge_n = 0;
  int   checks = 0;
  int   fails  = 0;
  exp_t sb[$];

  vehicle_sensor_conditioner_if bus ();

  vehicle_sensor_conditioner #(
    .DEBOUNCE(4), .OCC_MIN(8), .STUCK_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic expect_at(input int cyc, input int fld, input logic [31:0] mask,
                           input logic [31:0] val, input string nm);
    exp_t e;
    e.cyc = cyc; e.fld = fld; e.mask = mask; e.val = val; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic expect_bit(input int cyc, input int fld, input int b, input logic v,
                            input string nm);
    expect_at(cyc, fld, 32'h1 << b, 32'(v) << b, nm);
  endtask

  task automatic expect_arr(input int cyc, input int ch, input logic [7:0] cnt,
                            input string nm);
    expect_at(cyc, F_ARR, 32'hFF << (8 * ch), 32'(cnt) << (8 * ch), nm);
  endtask

  function automatic logic [31:0] field(input int fld);
    case (fld)
      F_S1:    return {28'd0, bus.sensor_1th};
      F_S5:    return {28'd0, bus.sensor_5th};
      F_ARR:   return bus.arrivals;
      default: return {28'd0, bus.fault};
    endcase
  endfunction

  task automatic to_edge(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] got;
  int          mk;
  always @(negedge clk) begin
    mk = 0;
    while (mk < sb.size()) begin
      if (sb[mk].cyc == edge_n) begin
        got = field(sb[mk].fld) & sb[mk].mask;
        checks++;
        if (got !== sb[mk].val) begin
          fails++;
          $display("FAIL %s edge %0d: got %h expected %h", sb[mk].nm, edge_n, got, sb[mk].val);
        end
        sb.delete(mk);
      end else begin
        mk++;
      end
    end
  end

  initial begin
    // Reset: outputs cleared while rst is high, despite toggling inputs and clear.
    for (int f = 0; f < 4; f++) begin
      expect_at(2, f, 32'hFFFF_FFFF, 32'h0, "reset_zero");
      expect_at(3, f, 32'hFFFF_FFFF, 32'h0, "post_reset_zero");
    end
    // North position-1: rise latency and fall latency.
    expect_bit(15, F_S1, 0, 1'b0, "n1_rise_early");
    expect_bit(16, F_S1, 0, 1'b1, "n1_rise");
    expect_arr(15, 0, 8'd0, "n_arr_before");
    expect_arr(16, 0, 8'd1, "n_arr_rise");
    expect_bit(45, F_S1, 0, 1'b1, "n1_fall_early");
    expect_bit(46, F_S1, 0, 1'b0, "n1_fall");
    // South position-5 with occupancy hold.
    expect_bit(26, F_S5, 2, 1'b0, "s5_deb_only");
    expect_bit(33, F_S5, 2, 1'b0, "s5_hold_early");
    expect_bit(34, F_S5, 2, 1'b1, "s5_rise");
    expect_bit(55, F_S5, 2, 1'b1, "s5_fall_early");
    expect_bit(56, F_S5, 2, 1'b0, "s5_fall");
    // East short glitch is rejected.
    expect_bit(64, F_S1, 1, 1'b0, "e1_glitch_a");
    expect_bit(66, F_S1, 1, 1'b0, "e1_glitch_b");
    expect_arr(70, 1, 8'd0, "e_arr_glitch");
    // West arrivals: counting, clear, clear coincident with arrival, saturation.
    expect_arr(86, 3, 8'd1, "w_arr_1");
    expect_arr(106, 3, 8'd2, "w_arr_2");
    expect_arr(140, 3, 8'd3, "w_arr_3");
    expect_arr(145, 3, 8'd0, "w_arr_clear");
    expect_arr(160, 3, 8'd1, "w_arr_after_clear");
    expect_arr(176, 3, 8'd1, "w_arr_clear_rise");
    expect_arr(180, 3, 8'd1, "w_arr_clear_rise_hold");
    expect_arr(3800, 3, 8'd255, "w_arr_saturate");
    expect_at(3800, F_ARR, 32'h00FF_FFFF, 32'h0000_0001, "other_arr_indep");
`ifdef STUCK_DETECT_EN
    expect_bit(3954, F_FLT, 0, 1'b0, "n_fault_early");
    expect_bit(3954, F_S1, 0, 1'b1, "n1_before_fault");
    expect_bit(3955, F_FLT, 0, 1'b1, "n_fault_set");
    expect_bit(3955, F_S1, 0, 1'b0, "n1_masked");
    expect_bit(4004, F_FLT, 0, 1'b1, "n_fault_held");
    expect_bit(4005, F_FLT, 0, 1'b0, "n_fault_clear");
    expect_bit(4005, F_S1, 0, 1'b0, "n1_no_glitch");
`else
    expect_bit(3955, F_FLT, 0, 1'b0, "n_fault_off");
    expect_bit(3955, F_S1, 0, 1'b1, "n1_unmasked");
    expect_bit(4004, F_FLT, 0, 1'b0, "n_fault_off_late");
`endif
    expect_arr(3910, 0, 8'd2, "n_arr_stuck_counts");

    rst = 1'b1;
    bus.raw_1th = 4'hF; bus.raw_5th = 4'hF; bus.clear = 4'hF;
    to_edge(1);
    bus.raw_1th = 4'hA; bus.raw_5th = 4'h5; bus.clear = 4'h0;
    to_edge(2);
    checks++;
    if (bus.arrivals !== 32'h0) begin
        fails++;
        $display("FAIL direct_reset_arrivals: got %h", bus.arrivals);
    end
    checks++;
    if (bus.sensor_1th !== 4'h0) begin
        fails++;
        $display("FAIL direct_reset_s1: got %h", bus.sensor_1th);
    end
    checks++;
    if (bus.sensor_5th !== 4'h0) begin
        fails++;
        $display("FAIL direct_reset_s5: got %h", bus.sensor_5th);
    end
    checks++;
    if (bus.fault !== 4'h0) begin
        fails++;
        $display("FAIL direct_reset_fault: got %h", bus.fault);
    end
    rst = 1'b0;
    bus.raw_1th = 4'h0; bus.raw_5th = 4'h0; bus.clear = 4'h0;

    to_edge(9);  bus.raw_1th[0] = 1'b1;
    to_edge(16);
    checks++;
    if (bus.sensor_1th[0] !== 1'b1) begin
        fails++;
        $display("FAIL direct_n1_rise: got %b", bus.sensor_1th[0]);
    end
    checks++;
    if (bus.arrivals[7:0] !== 8'd1) begin
        fails++;
        $display("FAIL direct_n_arr_rise: got %h", bus.arrivals[7:0]);
    end
    to_edge(19); bus.raw_5th[2] = 1'b1;
    to_edge(39); bus.raw_1th[0] = 1'b0;
    to_edge(49); bus.raw_5th[2] = 1'b0;
    to_edge(59); bus.raw_1th[1] = 1'b1;
    to_edge(62); bus.raw_1th[1] = 1'b0;

    for (int p = 0; p < 3; p++) begin
      to_edge(79 + 20 * p); bus.raw_1th[3] = 1'b1;
      to_edge(89 + 20 * p); bus.raw_1th[3] = 1'b0;
    end
    to_edge(144); bus.clear[3] = 1'b1;
    to_edge(145); bus.clear[3] = 1'b0;
    to_edge(149); bus.raw_1th[3] = 1'b1;
    to_edge(159); bus.raw_1th[3] = 1'b0;
    to_edge(169); bus.raw_1th[3] = 1'b1;
    to_edge(175); bus.clear[3] = 1'b1;
    to_edge(176); bus.clear[3] = 1'b0;
    to_edge(179); bus.raw_1th[3] = 1'b0;
    for (int p = 0; p < 300; p++) begin
      to_edge(189 + 12 * p); bus.raw_1th[3] = 1'b1;
      to_edge(195 + 12 * p); bus.raw_1th[3] = 1'b0;
    end

    to_edge(3899); bus.raw_1th[0] = 1'b1;
    to_edge(3999); bus.raw_1th[0] = 1'b0;
    to_edge(4020);

    while (sb.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL %s edge %0d: never sampled, expected %h", sb[0].nm, sb[0].cyc, sb[0].val);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
